// File: rtl/gpio_irq_pkg.sv
// Register map, ID value and shared helpers for the Wishbone GPIO interrupt controller.
package gpio_irq_pkg;

  typedef logic [31:0] word_t;

  localparam logic [6:0] REG_IN       = 7'h00;
  localparam logic [6:0] REG_IRQ_EN   = 7'h04;
  localparam logic [6:0] REG_IRQ_TYPE = 7'h08;
  localparam logic [6:0] REG_IRQ_POL  = 7'h0C;
  localparam logic [6:0] REG_IRQ_STAT = 7'h10;
  localparam logic [6:0] REG_DEB_DIV  = 7'h14;
  localparam logic [6:0] REG_ID       = 7'h18;

  localparam word_t GPIO_IRQ_ID = 32'h0A1B_0001;

  localparam int unsigned DEB_HIST = 3;

  // Expand the four byte strobes into a 32-bit write mask.
  function automatic word_t lane_mask(input logic [3:0] be);
    word_t m;
    for (int unsigned b = 0; b < 4; b++) m[8*b +: 8] = {8{be[b]}};
    return m;
  endfunction

endpackage

// File: rtl/gpio_sync_debounce.sv
// Pad synchronizer followed by a prescaled history debounce (present when GPIO_DEBOUNCE_EN is defined).
module gpio_sync_debounce
  import gpio_irq_pkg::*;
#(
  parameter int unsigned NUM_GPIO    = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DIV_W-1:0]    deb_div,
  input  logic                div_restart,
  input  logic [NUM_GPIO-1:0] gpio_in,
  output logic [NUM_GPIO-1:0] deb
);

  logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
  logic [NUM_GPIO-1:0] deb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  logic [DIV_W-1:0]    cnt_q;
  logic                tick;
  logic [NUM_GPIO-1:0] hist_q [DEB_HIST];
  logic [NUM_GPIO-1:0] all_one;
  logic [NUM_GPIO-1:0] any_one;

  assign tick = (cnt_q == deb_div);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      for (int unsigned j = 0; j < DEB_HIST; j++) hist_q[j] <= '0;
    end else begin
      if (div_restart || tick) cnt_q <= '0;
      else                     cnt_q <= cnt_q + DIV_W'(1);
      if (tick) begin
        hist_q[0] <= sync_q[SYNC_STAGES-1];
        for (int unsigned j = 1; j < DEB_HIST; j++) hist_q[j] <= hist_q[j-1];
      end
    end
  end

  always_comb begin
    all_one = '1;
    any_one = '0;
    for (int unsigned j = 0; j < DEB_HIST; j++) begin
      all_one &= hist_q[j];
      any_one |= hist_q[j];
    end
  end

  // Unanimous history forces the bit; mixed history leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) deb_q <= '0;
    else     deb_q <= all_one | (deb_q & any_one);
  end
`else
  logic unused_div;
  assign unused_div = ^{deb_div, div_restart};

  always_ff @(posedge clk) begin
    if (rst) deb_q <= '0;
    else     deb_q <= sync_q[SYNC_STAGES-1];
  end
`endif

  assign deb = deb_q;

endmodule

// File: rtl/gpio_irq_ctrl_wb.sv
// Wishbone GPIO edge/level interrupt controller; debounce stage selected by GPIO_DEBOUNCE_EN.
module gpio_irq_ctrl_wb
  import gpio_irq_pkg::*;
#(
  parameter int unsigned NUM_GPIO    = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DIV_W       = 16
) (
  input  logic                WB_CLK,
  input  logic                WB_RST,
  input  logic [6:0]          WBs_ADR,
  input  logic                WBs_CYC,
  input  logic [3:0]          WBs_BYTE_STB,
  input  logic                WBs_WE,
  input  logic                WBs_STB,
  input  logic [31:0]         WBs_WR_DAT,
  output logic [31:0]         WBs_RD_DAT,
  output logic                WBs_ACK,
  input  logic [NUM_GPIO-1:0] GPIO_i,
  output logic                Intr_o
);

`ifdef GPIO_DEBOUNCE_EN
  localparam word_t ID_VAL = GPIO_IRQ_ID;
`else
  localparam word_t ID_VAL = GPIO_IRQ_ID & 32'hFFFF_FF00;
`endif

  logic                ack_q;
  logic                intr_q;
  word_t               rd_q;
  word_t               rd_mux;
  word_t               wmask;
  word_t               wdat;
  logic [6:0]          addr;
  logic                req;
  logic                wr;
  logic                rd;
  logic                div_wr;
  logic [DIV_W-1:0]    div_q;
  logic [NUM_GPIO-1:0] en_q;
  logic [NUM_GPIO-1:0] type_q;
  logic [NUM_GPIO-1:0] pol_q;
  logic [NUM_GPIO-1:0] stat_q;
  logic [NUM_GPIO-1:0] deb;
  logic [NUM_GPIO-1:0] deb_prev_q;
  logic [NUM_GPIO-1:0] edge_hit;
  logic [NUM_GPIO-1:0] stat_view;
  logic [NUM_GPIO-1:0] w1c;
  logic                unused_adr;

  assign unused_adr = ^WBs_ADR[1:0];

  assign req    = WBs_CYC & WBs_STB & ~ack_q;
  assign wr     = req & WBs_WE;
  assign rd     = req & ~WBs_WE;
  assign addr   = {WBs_ADR[6:2], 2'b00};
  assign wmask  = lane_mask(WBs_BYTE_STB);
  assign wdat   = WBs_WR_DAT & wmask;
  assign div_wr = wr && (addr == REG_DEB_DIV);

  gpio_sync_debounce #(
    .NUM_GPIO    (NUM_GPIO),
    .SYNC_STAGES (SYNC_STAGES),
    .DIV_W       (DIV_W)
  ) u_sync_deb (
    .clk         (WB_CLK),
    .rst         (WB_RST),
    .deb_div     (div_q),
    .div_restart (div_wr),
    .gpio_in     (GPIO_i),
    .deb         (deb)
  );

  // Level bits report the live pin condition; edge bits report the sticky flop.
  always_comb begin
    edge_hit  = type_q & ((pol_q & deb & ~deb_prev_q) | (~pol_q & ~deb & deb_prev_q));
    stat_view = (type_q & stat_q) | (~type_q & ~(pol_q ^ deb));
    w1c       = (wr && (addr == REG_IRQ_STAT)) ? (wdat[NUM_GPIO-1:0] & type_q) : '0;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_IN:       rd_mux = 32'(deb);
      REG_IRQ_EN:   rd_mux = 32'(en_q);
      REG_IRQ_TYPE: rd_mux = 32'(type_q);
      REG_IRQ_POL:  rd_mux = 32'(pol_q);
      REG_IRQ_STAT: rd_mux = 32'(stat_view);
      REG_DEB_DIV:  rd_mux = 32'(div_q);
      REG_ID:       rd_mux = ID_VAL;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      ack_q      <= 1'b0;
      rd_q       <= '0;
      intr_q     <= 1'b0;
      en_q       <= '0;
      type_q     <= '0;
      pol_q      <= '0;
      stat_q     <= '0;
      deb_prev_q <= '0;
    end else begin
      ack_q      <= req;
      rd_q       <= rd ? rd_mux : '0;
      deb_prev_q <= deb;
      stat_q     <= (stat_q & ~w1c) | edge_hit;
      intr_q     <= |(stat_view & en_q);
      if (wr) begin
        case (addr)
          REG_IRQ_EN:   en_q   <= (en_q   & ~wmask[NUM_GPIO-1:0]) | wdat[NUM_GPIO-1:0];
          REG_IRQ_TYPE: type_q <= (type_q & ~wmask[NUM_GPIO-1:0]) | wdat[NUM_GPIO-1:0];
          REG_IRQ_POL:  pol_q  <= (pol_q  & ~wmask[NUM_GPIO-1:0]) | wdat[NUM_GPIO-1:0];
          default: ;
        endcase
      end
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  always_ff @(posedge WB_CLK) begin
    if (WB_RST)      div_q <= '0;
    else if (div_wr) div_q <= (div_q & ~wmask[DIV_W-1:0]) | wdat[DIV_W-1:0];
  end
`else
  assign div_q = '0;
`endif

  assign WBs_ACK    = ack_q;
  assign WBs_RD_DAT = rd_q;
  assign Intr_o     = intr_q;

endmodule

// File: doc/gpio_irq_ctrl_wb.md
Name: gpio_irq_ctrl_wb

Overview:
Wishbone slave that watches the GPIO input pins, synchronizes and debounces them, and detects edges or levels on each pin. It keeps per-pin interrupt status and drives one interrupt line to an FB_msg_out bit of the cell macro.
It sits alongside the GPIO controller IP on the WB_CLK domain. Address decode comes from the top level, which asserts WBs_CYC for this block's window only.

Parameters:
NUM_GPIO, 32, number of monitored pins (1..32)
SYNC_STAGES, 2, input synchronizer depth (>=2)
DIV_W, 16, width of debounce prescaler counter

Ports:
WB_CLK  input  1  Wishbone/fabric clock
WB_RST  input  1  synchronous active-high reset
WBs_ADR  input  7  byte offset in block window; [1:0] ignored
WBs_CYC  input  1  cycle select for this block
WBs_BYTE_STB  input  4  byte enables for writes
WBs_WE  input  1  write enable
WBs_STB  input  1  transfer strobe
WBs_WR_DAT  input  32  write data
WBs_RD_DAT  output  32  read data
WBs_ACK  output  1  transfer acknowledge
GPIO_i  input  NUM_GPIO  raw pad inputs, asynchronous
Intr_o  output  1  interrupt request, active-high level

Behaviour:
- Clocking and reset: one clock, WB_CLK. WB_RST is synchronous and active-high. All flops clear on a WB_RST-sampled edge.
- Reset values: WBs_ACK=0, WBs_RD_DAT=0, Intr_o=0. All registers, counters, synchronizer stages and debounced state are 0.
- Wishbone handshake:
  - Request = WBs_CYC & WBs_STB & ~WBs_ACK.
  - WBs_ACK pulses high for exactly one cycle, the cycle after the request, so one wait state per access.
  - Read data is registered and valid while WBs_ACK=1; WBs_RD_DAT=0 otherwise.
  - A write takes effect on the request cycle. Each byte lane is gated by WBs_BYTE_STB.
  - Back-to-back requests are spaced by the ACK cycle.
- Register map (word offsets); bits above NUM_GPIO read 0 and are not writable:
  - 0x00 IN: RO, debounced pin state.
  - 0x04 IRQ_EN: RW.
  - 0x08 IRQ_TYPE: RW; 1 = edge, 0 = level.
  - 0x0C IRQ_POL: RW; 1 = rising/high, 0 = falling/low.
  - 0x10 IRQ_STAT: W1C for edge bits; level bits read the live condition and ignore writes.
  - 0x14 DEB_DIV: RW, [DIV_W-1:0].
  - 0x18 ID: RO, 32'h0A1B_0001.
  - Unmapped offsets read 0; writes to them are ignored and still get ACK.
- Synchronizer: GPIO_i passes through SYNC_STAGES flops to give s[].
- Debounce:
  - A prescaler counts 0..DEB_DIV and produces tick=1 on wrap. DEB_DIV=0 gives a tick every cycle.
  - On each tick, each pin shifts s[i] into a 3-bit history.
  - deb[i] takes the history value only when all 3 history bits are equal; otherwise it holds.
  - A write to DEB_DIV restarts the prescaler at 0.
- Detection, per pin; d_prev = deb delayed one cycle:
  - rise = deb & ~d_prev; fall = ~deb & d_prev.
  - Edge mode sets stat[i] when (POL ? rise : fall) occurs. Detection is independent of IRQ_EN; the enable only masks Intr_o.
  - Level mode: stat[i] = POL ? deb[i] : ~deb[i], combinational into the status view.
- Simultaneous edge set and W1C clear on the same bit in the same cycle: set wins and the bit stays 1.
- Changing IRQ_TYPE or IRQ_POL does not clear stat. Software clears it.
- Intr_o is registered: the OR of (stat & IRQ_EN). It asserts 1 cycle after stat/en change.
- Latency from a pin change to Intr_o, with DEB_DIV=0: SYNC_STAGES + 3 (history) + 1 (deb) + 1 (stat) + 1 (Intr_o) cycles. With SYNC_STAGES=2 this is 8 cycles.
- WB_RST asserted mid-transfer: ACK is not issued and all state clears. The master retries.

Optional Feature:
GPIO_DEBOUNCE_EN
- Defined: the prescaler and history debounce are present as described above.
- Undefined: deb = s directly, giving 3 fewer cycles of latency. DEB_DIV reads 0 and writes to it are ignored. The ID low byte reads 0x00 instead of 0x01.

Decomposition:
- Shared package gpio_irq_pkg holds:
  - Register offset constants: REG_IN, REG_IRQ_EN, REG_IRQ_TYPE, REG_IRQ_POL, REG_IRQ_STAT, REG_DEB_DIV, REG_ID.
  - The ID value.
  - The history depth constant DEB_HIST=3.
- One sub-module, gpio_sync_debounce: synchronizer, prescaler and history for NUM_GPIO bits; outputs deb. The top level holds the Wishbone registers and detection logic.

Test Plan:
1. Reset, then read every register → IN=0, EN=0, STAT=0, ID=32'h0A1B_0001. Each ACK lasts exactly 1 cycle, 1 cycle after STB.
2. EN=0x1, TYPE=0x1, POL=0x1, DEB_DIV=0; drive GPIO_i[0] 0→1 → STAT=0x1 and Intr_o=1 exactly 8 cycles after the pin change. Write 0x1 to STAT → Intr_o=0 two cycles later.
3. Edge-mode bit 3 with an edge arriving on the same cycle as a W1C write of 0x8 → STAT[3] remains 1 and Intr_o stays 1.
4. Level-low mode on bit 5 (TYPE=0, POL=0, EN=0x20) with the pin held 0 → Intr_o=1. A W1C write has no effect; driving the pin to 1 drops Intr_o after the pipeline latency.
5. DEB_DIV=4; toggle GPIO_i[1] for 7 cycles then return it → IN[1] never changes and no STAT is set. Hold the pin high for 20 cycles → IN[1]=1.
6. Write IRQ_EN with BYTE_STB=4'b0010 and data 0xFFFF_FFFF → EN=0x0000_FF00. Write to offset 0x40 → gets ACK, read returns 0, no register changes.
